// File: rtl/wb_commit_trace.sv
// wb_commit_trace
//   Observes the writeback stage of the core and records every eligible
//   commit {rd, data, seq} into a first-word-fall-through trace FIFO that a
//   consumer drains over a valid/ready handshake. It also counts commits,
//   counts and flags entries lost to a full FIFO, and runs an idle watchdog.
//   It never back-pressures the core: a commit arriving at a full FIFO with
//   no pop in the same cycle is dropped, but its sequence number is still
//   used up, so the consumer can see the gap.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   wb_valid      writeback commits this cycle
//   wb_rd         destination register index
//   wb_data       value written back
//   out_valid     FIFO head is valid
//   out_ready     consumer accepts the head
//   out_rd        head rd
//   out_data      head data
//   out_seq       head sequence number
//   level         current occupancy
//   commit_count  eligible commits since reset (wraps)
//   drop_count    entries dropped on a full FIFO (saturates at 255)
//   overflow      sticky: at least one drop occurred
//   hang          sticky: watchdog expired
//   clr_flags     synchronous pulse clearing overflow, hang, drop_count
module wb_commit_trace #(
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 256,
    parameter int FILTER_X0 = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_valid,
    input  logic [4:0]                 wb_rd,
    input  logic [31:0]                wb_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0]                 out_rd,
    output logic [31:0]                out_data,
    output logic [15:0]                out_seq,
    output logic [$clog2(DEPTH):0]     level,
    output logic [31:0]                commit_count,
    output logic [7:0]                 drop_count,
    output logic                       overflow,
    output logic                       hang,
    input  logic                       clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [IW-1:0] TO_MAX  = IW'(TIMEOUT);
    localparam logic [IW-1:0] TO_M1   = IW'(TIMEOUT - 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [15:0] seq;
    } entry_t;

    entry_t          mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [15:0]     seq_r;
    logic [IW-1:0]   idle_r;

    logic            eligible_s;
    logic            full_s;
    logic            pop_s;
    logic            push_s;
    logic            drop_s;
    entry_t          new_entry_s;
    entry_t          head_next_s;
    logic [LW-1:0]   level_next_s;
    logic [AW-1:0]   rd_ptr_next_s;
    logic [IW-1:0]   idle_next_s;
    logic            hang_next_s;
    logic [7:0]      drop_next_s;
    logic            overflow_next_s;

    // Push/pop decisions and next-state of the occupancy, head and flags.
    always_comb begin
        eligible_s      = wb_valid && !((FILTER_X0 != 0) && (wb_rd == 5'd0));
        full_s          = (level == DEPTH_L);
        pop_s           = out_valid && out_ready;
        // A pop in the same cycle frees the slot the push needs.
        push_s          = eligible_s && (!full_s || pop_s);
        drop_s          = eligible_s && full_s && !pop_s;
        new_entry_s     = '{rd: wb_rd, data: wb_data, seq: seq_r};
        level_next_s    = level;
        rd_ptr_next_s   = rd_ptr_r;
        head_next_s     = '{rd: out_rd, data: out_data, seq: out_seq};
        idle_next_s     = idle_r;
        hang_next_s     = hang;
        drop_next_s     = drop_count;
        overflow_next_s = overflow;

        case ({push_s, pop_s})
            2'b10:   level_next_s = level + LW'(1);
            2'b01:   level_next_s = level - LW'(1);
            default: level_next_s = level;
        endcase

        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        // The new head is either the entry being pushed right now (FIFO
        // otherwise empty after this cycle's pop) or an already stored one.
        if (level_next_s == LW'(0)) begin
            head_next_s = '{rd: out_rd, data: out_data, seq: out_seq};
        end else if (push_s && (level_next_s == LW'(1))) begin
            head_next_s = new_entry_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end

        // A drop in the same cycle as clr_flags wins.
        if (drop_s) begin
            overflow_next_s = 1'b1;
            if (clr_flags) begin
                drop_next_s = 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_next_s = drop_count + 8'd1;
            end else begin
                drop_next_s = drop_count;
            end
        end else if (clr_flags) begin
            overflow_next_s = 1'b0;
            drop_next_s     = 8'd0;
        end else begin
            overflow_next_s = overflow;
            drop_next_s     = drop_count;
        end

        // Watchdog: any writeback (even rd==0) counts as activity.
        if (TIMEOUT == 0) begin
            idle_next_s = IW'(0);
            hang_next_s = 1'b0;
        end else if (clr_flags) begin
            idle_next_s = IW'(0);
            hang_next_s = 1'b0;
        end else if (wb_valid) begin
            idle_next_s = IW'(0);
            hang_next_s = hang;
        end else if (idle_r != TO_MAX) begin
            idle_next_s = idle_r + IW'(1);
            hang_next_s = hang || (idle_r == TO_M1);
        end else begin
            idle_next_s = idle_r;
            hang_next_s = hang;
        end
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            seq_r        <= 16'd0;
            idle_r       <= '0;
            level        <= '0;
            out_valid    <= 1'b0;
            out_rd       <= 5'd0;
            out_data     <= 32'd0;
            out_seq      <= 16'd0;
            commit_count <= 32'd0;
            drop_count   <= 8'd0;
            overflow     <= 1'b0;
            hang         <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (eligible_s) begin
                seq_r        <= seq_r + 16'd1;
                commit_count <= commit_count + 32'd1;
            end
            rd_ptr_r   <= rd_ptr_next_s;
            idle_r     <= idle_next_s;
            level      <= level_next_s;
            out_valid  <= (level_next_s != LW'(0));
            out_rd     <= head_next_s.rd;
            out_data   <= head_next_s.data;
            out_seq    <= head_next_s.seq;
            drop_count <= drop_next_s;
            overflow   <= overflow_next_s;
            hang       <= hang_next_s;
        end
    end

    // Trace storage; stale contents are harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= new_entry_s;
        end
    end

endmodule

// File: tb/tb_wb_commit_trace.sv
module tb_wb_commit_trace;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_ready;
    logic        clr_flags;

    logic        out_valid, b_out_valid;
    logic [4:0]  out_rd, b_out_rd;
    logic [31:0] out_data, b_out_data;
    logic [15:0] out_seq, b_out_seq;
    logic [2:0]  level, b_level;
    logic [31:0] commit_count, b_commit_count;
    logic [7:0]  drop_count, b_drop_count;
    logic        overflow, b_overflow;
    logic        hang, b_hang;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    wb_commit_trace #(.DEPTH(4), .TIMEOUT(8), .FILTER_X0(1)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data), .out_seq(out_seq),
        .level(level), .commit_count(commit_count), .drop_count(drop_count),
        .overflow(overflow), .hang(hang), .clr_flags(clr_flags)
    );

    // Same stimulus, x0 filter disabled.
    wb_commit_trace #(.DEPTH(4), .TIMEOUT(8), .FILTER_X0(0)) dut_b (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_rd(b_out_rd), .out_data(b_out_data), .out_seq(b_out_seq),
        .level(b_level), .commit_count(b_commit_count), .drop_count(b_drop_count),
        .overflow(b_overflow), .hang(b_hang), .clr_flags(clr_flags)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        rdy;
        logic        clr;
        logic [2:0]  lvl;
        logic        ov;
        logic        chk_head;
        logic [15:0] seq;
        logic [4:0]  hrd;
        logic [31:0] hdata;
        logic [7:0]  drop;
        logic        ovf;
        logic [31:0] cc;
        logic [2:0]  blvl;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic rdy, input logic clr);
        wb_valid  = v;
        wb_rd     = rd;
        wb_data   = d;
        out_ready = rdy;
        clr_flags = clr;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        //           v  rd     d         rdy clr lvl ov ch seq    hrd    hdata     drop ovf cc      blvl
        vecs[0]  = '{1, 5'd1,  32'h10,   0,  0,  1,  1, 1, 16'd0, 5'd1,  32'h10,   0,   0,  32'd1,  3'd1};
        vecs[1]  = '{1, 5'd2,  32'h11,   0,  0,  2,  1, 1, 16'd0, 5'd1,  32'h10,   0,   0,  32'd2,  3'd2};
        vecs[2]  = '{1, 5'd3,  32'h12,   0,  0,  3,  1, 1, 16'd0, 5'd1,  32'h10,   0,   0,  32'd3,  3'd3};
        vecs[3]  = '{1, 5'd4,  32'h13,   0,  0,  4,  1, 1, 16'd0, 5'd1,  32'h10,   0,   0,  32'd4,  3'd4};
        vecs[4]  = '{1, 5'd5,  32'h14,   0,  0,  4,  1, 1, 16'd0, 5'd1,  32'h10,   1,   1,  32'd5,  3'd4};
        vecs[5]  = '{1, 5'd6,  32'h15,   0,  0,  4,  1, 1, 16'd0, 5'd1,  32'h10,   2,   1,  32'd6,  3'd4};
        vecs[6]  = '{0, 5'd0,  32'h0,    1,  0,  3,  1, 1, 16'd1, 5'd2,  32'h11,   2,   1,  32'd6,  3'd3};
        vecs[7]  = '{0, 5'd0,  32'h0,    1,  0,  2,  1, 1, 16'd2, 5'd3,  32'h12,   2,   1,  32'd6,  3'd2};
        vecs[8]  = '{0, 5'd0,  32'h0,    1,  0,  1,  1, 1, 16'd3, 5'd4,  32'h13,   2,   1,  32'd6,  3'd1};
        vecs[9]  = '{0, 5'd0,  32'h0,    1,  0,  0,  0, 0, 16'd0, 5'd0,  32'h0,    2,   1,  32'd6,  3'd0};
        vecs[10] = '{1, 5'd7,  32'h20,   1,  0,  1,  1, 1, 16'd6, 5'd7,  32'h20,   2,   1,  32'd7,  3'd1};
        vecs[11] = '{1, 5'd0,  32'hDEAD, 0,  0,  1,  1, 1, 16'd6, 5'd7,  32'h20,   2,   1,  32'd7,  3'd2};
        vecs[12] = '{0, 5'd0,  32'h0,    1,  0,  0,  0, 0, 16'd0, 5'd0,  32'h0,    2,   1,  32'd7,  3'd1};
        vecs[13] = '{1, 5'd8,  32'h30,   0,  0,  1,  1, 1, 16'd7, 5'd8,  32'h30,   2,   1,  32'd8,  3'd2};
        vecs[14] = '{1, 5'd9,  32'h31,   0,  0,  2,  1, 1, 16'd7, 5'd8,  32'h30,   2,   1,  32'd9,  3'd3};
        vecs[15] = '{1, 5'd10, 32'h32,   0,  0,  3,  1, 1, 16'd7, 5'd8,  32'h30,   2,   1,  32'd10, 3'd4};
        vecs[16] = '{1, 5'd11, 32'h33,   0,  0,  4,  1, 1, 16'd7, 5'd8,  32'h30,   2,   1,  32'd11, 3'd4};
        vecs[17] = '{0, 5'd0,  32'h0,    0,  1,  4,  1, 1, 16'd7, 5'd8,  32'h30,   0,   0,  32'd11, 3'd4};

        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_seq", {16'd0, out_seq}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_commit", commit_count, 32'd0);
        chk("rst_drop", {24'd0, drop_count}, 32'd0);
        chk("rst_flags", {30'd0, overflow, hang}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Fill, overflow, drain, empty push+ready, x0 filter, refill, clr.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].v, vecs[i].rd, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            step();
            chk($sformatf("v%0d_level", i), {29'd0, level}, {29'd0, vecs[i].lvl});
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
            if (vecs[i].chk_head) begin
                chk($sformatf("v%0d_out_seq", i), {16'd0, out_seq}, {16'd0, vecs[i].seq});
                chk($sformatf("v%0d_out_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].hrd});
                chk($sformatf("v%0d_out_data", i), out_data, vecs[i].hdata);
            end
            chk($sformatf("v%0d_drop", i), {24'd0, drop_count}, {24'd0, vecs[i].drop});
            chk($sformatf("v%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
            chk($sformatf("v%0d_commit", i), commit_count, vecs[i].cc);
            chk($sformatf("v%0d_nofilter_level", i), {29'd0, b_level}, {29'd0, vecs[i].blvl});
        end

        // Full FIFO with push and pop every cycle: level holds, no drops.
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 5'(12 + k), 32'h34 + 32'(k), 1'b1, 1'b0);
            step();
            chk($sformatf("pp%0d_level", k), {29'd0, level}, 32'd4);
            chk($sformatf("pp%0d_drop", k), {24'd0, drop_count}, 32'd0);
            chk($sformatf("pp%0d_out_seq", k), {16'd0, out_seq}, 32'd8 + 32'(k));
            chk($sformatf("pp%0d_out_rd", k), {27'd0, out_rd}, 32'd9 + 32'(k));
            chk($sformatf("pp%0d_out_data", k), out_data, 32'h31 + 32'(k));
        end
        chk("pp_commit", commit_count, 32'd21);

        // Drop and clr_flags in the same cycle: the drop wins.
        drive(1'b1, 5'd1, 32'd0, 1'b0, 1'b1);
        step();
        chk("clrdrop_drop", {24'd0, drop_count}, 32'd1);
        chk("clrdrop_overflow", {31'd0, overflow}, 32'd1);
        chk("clrdrop_level", {29'd0, level}, 32'd4);
        chk("clrdrop_commit", commit_count, 32'd22);

        // Asynchronous reset between edges with three entries queued.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        step();
        chk("prerst_level", {29'd0, level}, 32'd3);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_level", {29'd0, level}, 32'd0);
        chk("arst_commit", commit_count, 32'd0);
        chk("arst_drop", {24'd0, drop_count}, 32'd0);
        chk("arst_overflow", {31'd0, overflow}, 32'd0);
        chk("arst_out_seq", {16'd0, out_seq}, 32'd0);
        step();
        reset = 1'b1;

        // Watchdog: hang on the 8th idle edge, not the 7th.
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("wd_idle%0d_hang", i), {31'd0, hang}, {31'd0, (i == 8)});
        end
        drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0);
        step();
        chk("wd_sticky_hang", {31'd0, hang}, 32'd1);
        chk("wd_x0_level", {29'd0, level}, 32'd0);
        chk("wd_x0_commit", commit_count, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        step();
        chk("wd_clr_hang", {31'd0, hang}, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("wd_restart%0d_hang", i), {31'd0, hang}, 32'd0);
        end
        // An rd==0 writeback still kicks the watchdog.
        drive(1'b1, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("wd_kick%0d_hang", i), {31'd0, hang}, {31'd0, (i == 8)});
        end

        // First eligible commit after reset carries seq 0.
        drive(1'b1, 5'd9, 32'h77, 1'b0, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        chk("post_out_valid", {31'd0, out_valid}, 32'd1);
        chk("post_out_seq", {16'd0, out_seq}, 32'd0);
        chk("post_out_rd", {27'd0, out_rd}, 32'd9);
        chk("post_out_data", out_data, 32'h77);
        chk("post_commit", commit_count, 32'd1);
        chk("post_level", {29'd0, level}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_commit_trace.md
Name: wb_commit_trace

Overview:
- Captures every retired writeback from the riscv core's WB stage (write-enable, destination register, WB_Data) into a first-word-fall-through trace FIFO.
- A consumer drains the FIFO over a valid/ready handshake; consumers are the bench scoreboard or a debug port.
- Also counts commits, flags dropped entries and runs a watchdog that reports a stalled pipeline.
- Sits directly downstream of the core's writeback stage and observes it only; it never back-pressures the core.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- TIMEOUT, 256, cycles without wb_valid before hang is set; 0 disables the watchdog.
- FILTER_X0, 1, when 1 a writeback with rd==0 is ignored: not stored, not counted, but it still kicks the watchdog.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- wb_valid  input  1  writeback commits this cycle.
- wb_rd  input  5  destination register index.
- wb_data  input  32  value written (WB_Data).
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head.
- out_rd  output  5  head rd.
- out_data  output  32  head data.
- out_seq  output  16  head sequence number.
- level  output  $clog2(DEPTH)+1  current occupancy.
- commit_count  output  32  eligible commits seen since reset.
- drop_count  output  8  entries dropped because the FIFO was full; saturates at 255.
- overflow  output  1  sticky: at least one drop occurred.
- hang  output  1  sticky: watchdog expired.
- clr_flags  input  1  synchronous pulse that clears overflow, hang and drop_count.

Behaviour:
- Reset (reset==0, asynchronous assert): empty FIFO; every output 0, including out_rd, out_data and out_seq. Sequence counter, commit counter and idle counter are 0. Release is synchronous to clk.
- Eligible commit: wb_valid && !(FILTER_X0 && wb_rd==0).
- Push on an eligible commit:
  - Stores {wb_rd, wb_data, seq}; then seq increments, wrapping 16'hFFFF->0.
  - commit_count increments for every eligible commit, including dropped ones, and wraps.
- Pop: out_valid && out_ready at the rising edge. The head advances next cycle.
- FWFT timing: an entry pushed at edge N is visible on out_* after edge N (one-cycle latency). No combinational path from wb_* to out_*.
- out_* hold their value while out_valid && !out_ready. When empty, out_valid==0 and out_rd/out_data/out_seq hold their last value (don't-care for checking).
- Full and no pop in the same cycle:
  - The push is dropped. seq still increments, so the consumer sees a gap.
  - drop_count increments (saturating) and overflow is set.
- Full with pop in the same cycle: push succeeds and level stays DEPTH.
- Empty with push and out_ready in the same cycle: no pop (out_valid was 0); level becomes 1.
- level updates as +1, -1 or 0 depending on the push/pop combination.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Watchdog (TIMEOUT>0):
  - The idle counter clears on any wb_valid, including rd==0; otherwise it increments, saturating at TIMEOUT.
  - hang is set on the edge where the counter reaches TIMEOUT and stays set after activity resumes.
- clr_flags:
  - Clears overflow, hang and drop_count, and restarts the idle counter.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
  - Does not touch FIFO contents, seq or commit_count.
- Reset mid-operation discards all contents immediately. There is no partial-entry state.

Test Plan:
- FIFO fill and order: DEPTH=4, out_ready=0, commits rd=1..4 with data 32'h10..32'h13 -> level=4, out_valid=1, head rd=1, data=32'h10, seq=0. Then out_ready=1 -> pops in order seq 0,1,2,3, level reaches 0.
- Overflow: with the FIFO full (seq 0-3), two more commits -> drop_count=2, overflow=1, commit_count=6. A later commit stores seq=6 after the drains.
- x0 filter: FILTER_X0=1, commit rd=0 data=32'hDEAD -> level unchanged, commit_count unchanged, idle counter cleared. FILTER_X0=0 -> the entry is stored.
- Full with simultaneous push and pop: level=4, out_ready=1, wb_valid=1 for 10 cycles -> level stays 4, drop_count=0, out_seq increments each cycle.
- Watchdog: TIMEOUT=8, no wb_valid after reset release -> hang=1 on the 8th edge, not the 7th. A wb_valid then keeps hang=1; clr_flags -> hang=0 and the count restarts.
- Async reset mid-stream: reset driven low between clock edges with level=3 -> out_valid=0, level=0, all counters 0 immediately. The first commit after release has seq=0.
